// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream image loader; packs big-endian words into imem
//               and holds the core in reset until a full image is written.
//               Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [0:7]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [0:31]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_len_hi = 3'd1;
  localparam logic [2:0] c_len_lo = 3'd2;
  localparam logic [2:0] c_data   = 3'd3;
  localparam logic [2:0] c_csum   = 3'd4;
  localparam logic [2:0] c_done   = 3'd5;
  localparam logic [2:0] c_err    = 3'd6;

  localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit c_csum_en = 1'b1;
`else
  localparam bit c_csum_en = 1'b0;
`endif

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              w_ready;
  logic              w_xfer;
  logic              w_start_ok;
  logic              w_last_byte;
  logic              w_last_word;
  logic [15:0]       w_len;
  logic [15:0]       w_count_inc;
  logic [0:31]       w_word_shift;

  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [1:0]        r_byte_idx;
  logic [0:31]       r_word;
  logic [7:0]        r_csum;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [0:31]       r_wdata;
  logic              r_we;
  logic [15:0]       r_word_count;
  logic              r_core_hold;
  logic              r_done;
  logic              r_err;

  assign w_xfer       = byte_valid & w_ready;
  assign w_start_ok   = start & ((r_state == c_idle) | (r_state == c_done) | (r_state == c_err));
  assign w_len        = {r_len_hi, byte_in};
  assign w_count_inc  = r_word_count + 16'd1;
  assign w_word_shift = {r_word[8:31], byte_in};
  assign w_last_byte  = (r_state == c_data) & w_xfer & (r_byte_idx == 2'd3);
  // r_word_count counts words already completed, so +1 names the word finishing now
  assign w_last_word  = w_last_byte & (w_count_inc == r_len);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle, c_done, c_err: begin
        if (start) w_next = c_len_hi;
      end
      c_len_hi: begin
        if (w_xfer) w_next = c_len_lo;
      end
      c_len_lo: begin
        if (w_xfer) begin
          if (w_len == 16'd0)                    w_next = c_csum_en ? c_csum : c_done;
          else if ({1'b0, w_len} > c_max_words)  w_next = c_err;
          else                                   w_next = c_data;
        end
      end
      c_data: begin
        if (w_last_word) w_next = c_csum_en ? c_csum : c_done;
      end
      c_csum: begin
        if (w_xfer) w_next = (byte_in == r_csum) ? c_done : c_err;
      end
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      c_len_hi, c_len_lo, c_data, c_csum: w_ready = 1'b1;
      default:                            w_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_len_hi     <= 8'd0;
      r_len        <= 16'd0;
      r_byte_idx   <= 2'd0;
      r_word       <= 32'd0;
      r_csum       <= 8'd0;
      r_waddr      <= '0;
      r_imem_addr  <= '0;
      r_wdata      <= 32'd0;
      r_we         <= 1'b0;
      r_word_count <= 16'd0;
      r_core_hold  <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we        <= 1'b0;
      r_done      <= (w_next == c_done);
      r_err       <= (w_next == c_err);
      r_core_hold <= (w_next != c_done);
      if (w_start_ok) begin
        r_word_count <= 16'd0;
        r_waddr      <= '0;
        r_imem_addr  <= '0;
        r_byte_idx   <= 2'd0;
        r_csum       <= 8'd0;
      end
      if ((r_state == c_len_hi) && w_xfer) r_len_hi <= byte_in;
      if ((r_state == c_len_lo) && w_xfer) r_len    <= w_len;
      if ((r_state == c_data) && w_xfer) begin
        r_word     <= w_word_shift;
        r_byte_idx <= r_byte_idx + 2'd1;
        r_csum     <= r_csum ^ byte_in;
        // Strobe lands one cycle after the 4th byte; capture current address with it
        if (r_byte_idx == 2'd3) begin
          r_we         <= 1'b1;
          r_wdata      <= w_word_shift;
          r_imem_addr  <= r_waddr;
          r_waddr      <= r_waddr + 1'b1;
          r_word_count <= w_count_inc;
        end
      end
    end
  end

  assign byte_ready = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_wdata;
  assign core_hold  = r_core_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader with a stream-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit c_csum_en = 1'b1;
`else
  localparam bit c_csum_en = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [15:0]       word_count;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_we_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr %0h data %0h expected none", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(imem_addr), 64'(e.a));
        chk("write_data", 64'(imem_wdata), 64'(e.d));
        last_we_cyc = cyc;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
    int t;
    if (gap > 0) begin
      @(negedge clk);
      byte_valid = 1'b0;
      start      = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    start      = inj && ($urandom_range(0, 3) == 0);
    t = 0;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout actual 0 expected 1");
    end
    @(posedge clk);
  endtask

  // Model: length header, then 4 bytes per word MSB first; word i goes to address i
  task automatic run_load(input int n, input int maxgap, input bit bad_csum,
                          input bit inj, input bit fixed, input int gap_idx);
    logic [7:0]  q[$];
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] nl;
    bit          len_ok;
    bit          exp_done;
    int          t;
    int          done_cyc;
    int          g;
    nl     = 16'(n);
    x      = 8'h00;
    len_ok = (n <= MAX_WORDS);
    q.push_back(nl[15:8]);
    q.push_back(nl[7:0]);
    if (len_ok) begin
      for (int i = 0; i < n; i++) begin
        w = fixed ? ((i == 0) ? 32'h2001_0005 : 32'h2002_0007) : $urandom;
        for (int k = 3; k >= 0; k--) begin
          q.push_back(w[8*k +: 8]);
          x = x ^ w[8*k +: 8];
        end
        exp_q.push_back('{a: ADDR_W'(i), d: w});
      end
      if (c_csum_en) q.push_back(bad_csum ? (x ^ 8'h01) : x);
    end
    exp_done = len_ok && !(c_csum_en && bad_csum);

    pulse_start();
    chk("start_core_hold", 64'(core_hold), 64'd1);
    chk("start_clears_done", 64'({done, err}), 64'd0);
    chk("start_clears_count", 64'(word_count), 64'd0);

    for (int i = 0; i < q.size(); i++) begin
      g = (i == gap_idx) ? 4 : int'($urandom_range(0, maxgap));
      send_byte(q[i], g, inj && (i >= 1));
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    t = 0;
    while (!(done || err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    done_cyc = cyc;
    chk("end_seen", 64'(done || err), 64'd1);
    chk("end_done", 64'(done), 64'(exp_done));
    chk("end_err", 64'(err), 64'(!exp_done));
    chk("end_core_hold", 64'(core_hold), 64'(!exp_done));
    chk("end_word_count", 64'(word_count), len_ok ? 64'(n) : 64'd0);
    @(negedge clk);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    if (exp_done && n > 0) begin
      if (c_csum_en) chk("done_after_last_we", 64'(done_cyc > last_we_cyc), 64'd1);
      else           chk("done_with_last_we", 64'(done_cyc), 64'(last_we_cyc));
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", 64'(byte_ready), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_core_hold", 64'(core_hold), 64'd1);
    chk("rst_done_err", 64'({done, err}), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_addr_data", 64'({imem_addr, imem_wdata}), 64'd0);
    reset = 1'b1;

    run_load(2, 0, 1'b0, 1'b0, 1'b1, -1);
    run_load(2, 0, 1'b0, 1'b0, 1'b1, 4);
    run_load(0, 0, 1'b0, 1'b0, 1'b0, -1);
    run_load(257, 0, 1'b0, 1'b0, 1'b0, -1);
    run_load(3, 1, 1'b0, 1'b0, 1'b0, -1);

    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h20, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    reset      = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_byte_ready", 64'(byte_ready), 64'd0);
    chk("midrst_core_hold", 64'(core_hold), 64'd1);
    chk("midrst_word_count", 64'(word_count), 64'd0);
    chk("midrst_done_err", 64'({done, err}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_load(int'($urandom_range(1, 8)), 2, (k == 3), 1'b1, 1'b0, -1);
    end
    run_load(MAX_WORDS, 0, 1'b0, 1'b0, 1'b0, -1);
    run_load(2, 0, 1'b1, 1'b0, 1'b1, -1);
    run_load(1, 1, 1'b0, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
